// File: rtl/rss_pipe_if.sv
// ============================================================================
// Module  : rss_pipe_if
// Brief   : Operand/result handshake bundle for the rss_pipe right shifter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rss_pipe_if #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = $clog2(WIDTH) + 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SHIFT_WIDTH-1:0] in_shamt;
  logic                   in_arith;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_sticky;

  modport slave (
    input  in_valid, in_data, in_shamt, in_arith, out_ready,
    output in_ready, out_valid, out_data, out_sticky
  );

  modport master (
    output in_valid, in_data, in_shamt, in_arith, out_ready,
    input  in_ready, out_valid, out_data, out_sticky
  );
endinterface

`default_nettype wire

// File: rtl/rss_pipe.sv
// ============================================================================
// Module  : rss_pipe
// Brief   : Pipelined right shifter with sticky collection and arith fill.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rss_pipe #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = $clog2(WIDTH) + 1,
  parameter int STAGES      = 2
) (
  input  logic      clk,
  input  logic      rst,
  rss_pipe_if.slave bus
);

  localparam int               c_FULL_LVL = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_ONES     = {WIDTH{1'b1}};

  function automatic int stage_of(input int k);
    return (k * STAGES) / SHIFT_WIDTH;
  endfunction

  function automatic int last_level(input int s);
    int r;
    r = 0;
    for (int k = 0; k < SHIFT_WIDTH; k++) begin
      if (stage_of(k) == s) r = k;
    end
    return r;
  endfunction

  logic [STAGES-1:0]      w_stg_valid;
  logic [STAGES-1:0]      w_stg_sticky;
  logic [STAGES-1:0]      w_stg_fill;
  logic [STAGES-1:0]      w_src_fill;
  logic [STAGES-1:0]      w_rdy;
  logic [WIDTH-1:0]       w_stg_data [STAGES];
  logic [SHIFT_WIDTH-1:0] w_stg_amt  [STAGES];
  logic [SHIFT_WIDTH-1:0] w_src_amt  [STAGES];
  logic                   w_unused_tail;

  // A stage can take new contents if it, or any stage after it, has a hole.
  for (genvar s = 0; s < STAGES; s++) begin : g_rdy
    assign w_rdy[s] = bus.out_ready || !(&w_stg_valid[STAGES-1:s]);
  end

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_lvl
    localparam int c_STG = stage_of(k);
    logic [WIDTH-1:0]       din;
    logic [WIDTH-1:0]       dout;
    logic                   sin;
    logic                   sout;
    logic                   fill;
    logic [SHIFT_WIDTH-1:0] amt;

    assign fill = w_src_fill[c_STG];
    assign amt  = w_src_amt[c_STG];

    if (k == 0) begin : g_src_port
      assign din = bus.in_data;
      assign sin = 1'b0;
    end else if (stage_of(k - 1) != c_STG) begin : g_src_reg
      assign din = w_stg_data[c_STG-1];
      assign sin = w_stg_sticky[c_STG-1];
    end else begin : g_src_lvl
      assign din = g_lvl[k-1].dout;
      assign sin = g_lvl[k-1].sout;
    end

    if (k >= c_FULL_LVL) begin : g_full
      assign dout = amt[k] ? {WIDTH{fill}} : din;
      assign sout = sin | (amt[k] & (|din));
    end else begin : g_part
      localparam int               c_SH  = 1 << k;
      localparam logic [WIDTH-1:0] c_LOW = c_ONES >> (WIDTH - c_SH);
      localparam logic [WIDTH-1:0] c_TOP = ~(c_ONES >> c_SH);
      assign dout = amt[k] ? ((din >> c_SH) | ({WIDTH{fill}} & c_TOP)) : din;
      assign sout = sin | (amt[k] & (|(din & c_LOW)));
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int c_LAST = last_level(s);
    logic                   up_valid;
    logic                   valid_q;
    logic                   sticky_q;
    logic                   fill_q;
    logic [WIDTH-1:0]       data_q;
    logic [SHIFT_WIDTH-1:0] amt_q;
    logic [WIDTH-1:0]       data_d;
    logic                   sticky_d;

    if (s == 0) begin : g_head
      assign up_valid     = bus.in_valid;
      assign w_src_fill[s] = bus.in_arith & bus.in_data[WIDTH-1];
      assign w_src_amt[s]  = bus.in_shamt;
    end else begin : g_body
      assign up_valid     = w_stg_valid[s-1];
      assign w_src_fill[s] = w_stg_fill[s-1];
      assign w_src_amt[s]  = w_stg_amt[s-1];
    end

    assign data_d   = g_lvl[c_LAST].dout;
    assign sticky_d = g_lvl[c_LAST].sout;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q  <= 1'b0;
        data_q   <= '0;
        sticky_q <= 1'b0;
        fill_q   <= 1'b0;
        amt_q    <= '0;
      end else if (w_rdy[s]) begin
        valid_q <= up_valid;
        if (up_valid) begin
          data_q   <= data_d;
          sticky_q <= sticky_d;
          fill_q   <= w_src_fill[s];
          amt_q    <= w_src_amt[s];
        end
      end
    end

    assign w_stg_valid[s]  = valid_q;
    assign w_stg_data[s]   = data_q;
    assign w_stg_sticky[s] = sticky_q;
    assign w_stg_fill[s]   = fill_q;
    assign w_stg_amt[s]    = amt_q;
  end

  // The final stage's fill and shift amount have no consumer downstream.
  assign w_unused_tail = w_stg_fill[STAGES-1] ^ (^w_stg_amt[STAGES-1]);

  assign bus.in_ready   = !rst && w_rdy[0];
  assign bus.out_valid  = w_stg_valid[STAGES-1];
  assign bus.out_sticky = w_stg_sticky[STAGES-1];
  assign bus.out_data   = {w_stg_data[STAGES-1][WIDTH-1:1],
                           w_stg_data[STAGES-1][0] | w_stg_sticky[STAGES-1]};

endmodule

`default_nettype wire

// File: tb/tb_rss_pipe.sv
// ============================================================================
// Module  : tb_rss_pipe
// Brief   : Self-checking bench for rss_pipe (WIDTH=32, STAGES=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rss_pipe;

  localparam int c_W  = 32;
  localparam int c_SW = 6;
  localparam int c_N  = 10000;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  sh;
    logic        ar;
    logic [31:0] exp_d;
    logic        exp_s;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   n_acc;
  int   n_out;
  logic [32:0] exp_q [$];
  logic        hold_pending;
  logic [32:0] held;
  vec_t        vecs [10];
  logic [31:0] bp_d [6];

  rss_pipe_if #(.WIDTH(c_W), .SHIFT_WIDTH(c_SW)) bus ();

  rss_pipe #(.WIDTH(c_W), .SHIFT_WIDTH(c_SW), .STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: {sticky, folded result} computed directly from the shift rules.
  function automatic logic [32:0] model(input logic [31:0] d, input int sh, input logic ar);
    logic [31:0] s;
    logic        st;
    logic        fill;
    fill = ar & d[31];
    if (sh >= 32) begin
      s  = {32{fill}};
      st = |d;
    end else begin
      s  = ar ? 32'($signed(d) >>> sh) : (d >> sh);
      st = |(d & ((32'd1 << sh) - 32'd1));
    end
    s[0] = s[0] | st;
    return {st, s};
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom & 32'h0000_00FF;
      2:       return $urandom | 32'h8000_0000;
      default: return 32'h1 << $urandom_range(0, 31);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_data, int'(bus.in_shamt), bus.in_arith));
        n_acc++;
      end
      if (hold_pending) begin
        check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        check("hold_stable", {31'd0, bus.out_sticky, bus.out_data}, {31'd0, held});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got beat %0h with no beat outstanding", bus.out_data);
        end else begin
          check("sb_beat", {31'd0, bus.out_sticky, bus.out_data}, {31'd0, exp_q.pop_front()});
        end
        n_out++;
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      held         = {bus.out_sticky, bus.out_data};
    end
  end

  task automatic run_vec(input vec_t v);
    int lat;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_data   = v.d;
    bus.in_shamt  = v.sh;
    bus.in_arith  = v.ar;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("vec_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check("vec_latency", 64'(lat), 64'd2);
    check("vec_data", {32'd0, bus.out_data}, {32'd0, v.exp_d});
    check("vec_sticky", {63'd0, bus.out_sticky}, {63'd0, v.exp_s});
  endtask

  initial begin
    int base;
    int base_out;
    int bi;
    int c;

    tests = 0; fails = 0; n_acc = 0; n_out = 0; hold_pending = 1'b0; held = '0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0; bus.in_arith = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{32'h0000_00F0, 6'd4,  1'b0, 32'h0000_000F, 1'b0};
    vecs[1] = '{32'h0000_0028, 6'd4,  1'b0, 32'h0000_0003, 1'b1};
    vecs[2] = '{32'h8000_0000, 6'd4,  1'b1, 32'hF800_0000, 1'b0};
    vecs[3] = '{32'h8000_0001, 6'd40, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h7FFF_FFFF, 6'd31, 1'b1, 32'h0000_0001, 1'b1};
    vecs[5] = '{32'h0000_0001, 6'd32, 1'b0, 32'h0000_0001, 1'b1};
    vecs[6] = '{32'h0000_0000, 6'd63, 1'b0, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'hDEAD_BEEF, 6'd0,  1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[8] = '{32'h8000_0000, 6'd31, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[9] = '{32'h4000_0000, 6'd8,  1'b1, 32'h0040_0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    check("rst_out_sticky", {63'd0, bus.out_sticky}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Directed vectors
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: 6 beats against a stalled output
    for (int i = 0; i < 6; i++) bp_d[i] = 32'h1111_0000 * (i + 1) + 32'(i * 7);
    @(posedge clk); #1;
    base = n_acc; base_out = n_out;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = bp_d[0];
    bus.in_shamt  = 6'd3;
    bus.in_arith  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bi = n_acc - base;
      if (bi < 6) bus.in_data = bp_d[bi];
      else bus.in_valid = 1'b0;
    end
    check("bp_accepted", 64'(n_acc - base), 64'd2);
    check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    bus.out_ready = 1'b1;
    c = 0;
    while (c < 30 && (n_out - base_out) < 6) begin
      @(posedge clk); #1;
      c++;
      bi = n_acc - base;
      if (bi < 6) bus.in_data = bp_d[bi];
      else bus.in_valid = 1'b0;
    end
    check("bp_drain_cycles", 64'(c), 64'd6);
    check("bp_out_count", 64'(n_out - base_out), 64'd6);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hCAFE_F00D;
    bus.in_shamt  = 6'd5;
    bus.in_arith  = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("midrst_out_data", {32'd0, bus.out_data}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("midrst_release_ready", {63'd0, bus.in_ready}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_stale", {63'd0, bus.out_valid}, 64'd0);
    end
    run_vec(vecs[1]);

    // Randomised traffic against the reference model
    @(posedge clk); #1;
    base = n_acc;
    c = 0;
    while (c < 60000 && ((n_acc - base) < c_N || exp_q.size() != 0)) begin
      @(posedge clk); #1;
      c++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ((n_acc - base) < c_N) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = rand_data();
        bus.in_shamt = 6'($urandom_range(0, 63));
        bus.in_arith = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    check("rand_accepted", 64'(n_acc - base), 64'(c_N));
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
